// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: stall vector codes, controller state encodings and the
// stall priority helper shared by the pipeline sequencing controller.
`default_nettype none

package pipe_stall_ctrl_pkg;

  typedef logic [5:0] stall_vec_t;

  localparam stall_vec_t STALL_NONE    = 6'b000000;
  localparam stall_vec_t STALL_FROM_ID = 6'b000111;
  localparam stall_vec_t STALL_FROM_EX = 6'b001111;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_RUN  = 2'd1;
  localparam logic [1:0] CTRL_DONE = 2'd2;

  // Flush wins over everything, then the EX freeze, then the load-use bubble.
  function automatic stall_vec_t stall_select(input logic flush_req,
                                              input logic ex_stall,
                                              input logic id_stall);
    if (flush_req)     return STALL_NONE;
    else if (ex_stall) return STALL_FROM_EX;
    else if (id_stall) return STALL_FROM_ID;
    else               return STALL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: request/response bundle between the pipeline stages
// (master) and the stall controller (slave). PIPE_CTRL_PERF_EN adds counters.
`default_nettype none

interface pipe_stall_ctrl_if
`ifdef PIPE_CTRL_PERF_EN
  #(parameter int CNT_W = 6, parameter int PERF_W = 32)
`else
  #(parameter int CNT_W = 6)
`endif
  ();
  import pipe_stall_ctrl_pkg::*;

  logic             stallreq_id;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_len;
  logic             ex_mc_abort;
  logic             flush_req;
  stall_vec_t       stall;
  logic             flush;
  logic             ex_mc_done;
  logic             busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_stall_cyc;
  logic [PERF_W-1:0] perf_mc_ops;
`endif

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_len, ex_mc_abort, flush_req,
`ifdef PIPE_CTRL_PERF_EN
    input  perf_stall_cyc, perf_mc_ops,
`endif
    input  stall, flush, ex_mc_done, busy
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_len, ex_mc_abort, flush_req,
`ifdef PIPE_CTRL_PERF_EN
    output perf_stall_cyc, perf_mc_ops,
`endif
    output stall, flush, ex_mc_done, busy
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl_mc_down_counter.sv
// mc_down_counter: loadable down-counter with zero/one flags used to time
// multi-cycle EX operations.
`default_nettype none

module mc_down_counter #(
  parameter int CNT_W = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero,
  output logic                  o_one
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)        r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);
  assign o_one  = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/EX stall requests with the MEM flush and freezes
// EX for multi-cycle ops. Optional counters under macro PIPE_CTRL_PERF_EN.
`default_nettype none

module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_stall_ctrl_if.slave  bus
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_done;
  logic       w_kill;
  logic       w_start;
  logic       w_ex_stall;
  logic       w_cnt_zero;
  logic       w_cnt_one;
  stall_vec_t w_stall;

  assign w_kill     = bus.flush_req | bus.ex_mc_abort;
  assign w_start    = ((r_state == CTRL_IDLE) | (r_state == CTRL_DONE)) &
                      bus.ex_mc_start & (bus.ex_mc_len != '0);
  assign w_ex_stall = ~w_kill & ((r_state == CTRL_RUN) | w_start);

  always_comb begin
    w_next = CTRL_IDLE;
    if (w_kill)
      w_next = CTRL_IDLE;
    else if (w_start)
      w_next = (bus.ex_mc_len == CNT_W'(1)) ? CTRL_DONE : CTRL_RUN;
    else if (r_state == CTRL_RUN)
      w_next = (w_cnt_one | w_cnt_zero) ? CTRL_DONE : CTRL_RUN;
  end

  // Counter holds cycles still to go after the current one.
  mc_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_kill | w_start),
    .i_load_val(w_kill ? '0 : bus.ex_mc_len - CNT_W'(1)),
    .i_dec     (~w_kill & (r_state == CTRL_RUN)),
    .o_zero    (w_cnt_zero),
    .o_one     (w_cnt_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CTRL_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == CTRL_DONE);
    end
  end

  assign w_stall        = stall_select(bus.flush_req, w_ex_stall, bus.stallreq_id);
  assign bus.stall      = w_stall;
  assign bus.flush      = bus.flush_req;
  assign bus.ex_mc_done = r_done;
  assign bus.busy       = (r_state != CTRL_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_ops;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_ops   <= '0;
    end else begin
      if ((w_stall != STALL_NONE) && !(&r_perf_stall))
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (r_done && !(&r_perf_ops))
        r_perf_ops <= r_perf_ops + PERF_W'(1);
    end
  end

  assign bus.perf_stall_cyc = r_perf_stall;
  assign bus.perf_mc_ops    = r_perf_ops;
`endif

`ifndef SYNTHESIS
  // A new op cannot be accepted while one is still counting down.
  a_no_start_in_run: assert property (@(posedge clk) disable iff (rst)
    !(bus.ex_mc_start && (r_state == CTRL_RUN)))
    else $error("ex_mc_start asserted while multi-cycle op in RUN");
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed plus randomized stimulus against a
// remaining-cycles reference model of the stall controller.
`default_nettype none

module tb_pipe_stall_ctrl;

  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(32)) bus ();
  pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycles of EX freeze still owed, and whether this cycle is the done cycle.
  int m_rem  = 0;
  bit m_done = 1'b0;
  int m_perf_stall = 0;
  int m_perf_ops   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit id, input bit st, input int len,
                      input bit ab, input bit fl);
    bit         ex;
    logic [5:0] e_stall;
    @(negedge clk);
    rst             = r;
    bus.stallreq_id = id;
    bus.ex_mc_start = st;
    bus.ex_mc_len   = CNT_W'(len);
    bus.ex_mc_abort = ab;
    bus.flush_req   = fl;
    #1;
    ex = !fl && !ab && (m_rem > 0 || (m_rem == 0 && st && len != 0));
    e_stall = fl ? 6'h00 : ex ? 6'h0F : id ? 6'h07 : 6'h00;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("flush", 32'(bus.flush), 32'(fl));
    chk("busy",  32'(bus.busy),  32'(m_rem > 0 || m_done));
    chk("done",  32'(bus.ex_mc_done), 32'(m_done));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", bus.perf_stall_cyc, 32'(m_perf_stall));
    chk("perf_ops",   bus.perf_mc_ops,    32'(m_perf_ops));
`endif
    if (r) begin
      m_rem = 0; m_done = 0; m_perf_stall = 0; m_perf_ops = 0;
    end else begin
      if (e_stall != 6'h00) m_perf_stall++;
      if (m_done) m_perf_ops++;
      if (fl || ab) begin
        m_rem = 0; m_done = 0;
      end else begin
        if (m_rem == 0 && st && len != 0) m_rem = len;
        if (ex) begin
          m_rem--;
          m_done = (m_rem == 0);
        end else begin
          m_done = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.stallreq_id = 0; bus.ex_mc_start = 0; bus.ex_mc_len = '0;
    bus.ex_mc_abort = 0; bus.flush_req = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use only.
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); idle(1);
    // len=3 with ID stall held throughout.
    step(0, 1, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    idle(1);
    // len=1 and len=0.
    step(0, 0, 1, 1, 0, 0); idle(3);
    step(0, 0, 1, 0, 0, 0); idle(2);
    // len=5 killed by flush, then by abort, at cycle 2.
    step(0, 0, 1, 5, 0, 0); idle(1); step(0, 0, 0, 0, 0, 1); idle(7);
    step(0, 0, 1, 5, 0, 0); idle(1); step(0, 0, 0, 0, 1, 0); idle(7);
    // Back-to-back len=2 ops, second started in the DONE cycle.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0); idle(1); step(0, 0, 1, 2, 0, 0); idle(4);
    // Max length op, flush racing a start, reset mid-op.
    step(0, 0, 1, 63, 0, 0); idle(64);
    step(0, 0, 1, 4, 0, 1); idle(2);
    step(0, 0, 1, 6, 0, 0); idle(2); step(1, 0, 0, 0, 0, 0); idle(3);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, id, st, ab, fl;
      int len;
      r   = ($urandom % 90) == 0;
      id  = ($urandom % 3) == 0;
      st  = (m_rem == 0) && (($urandom % 3) == 0);
      len = (($urandom % 10) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      ab  = ($urandom % 30) == 0;
      fl  = ($urandom % 30) == 0;
      step(r, id, st, len, ab, fl);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
